tmds_link_ctrl: RTL and testbench
=================================

TMDS_LINK_CTRL -- requirements
Module: tmds_link_ctrl

Interface
REQ-001 The block SHALL have parameter kRstCycles, default 16, giving the number of PixelClk cycles the serialisers are held in reset after lock (legal 1..255).
REQ-002 The block SHALL have parameter kSettleCycles, default 64, giving the number of PixelClk cycles of forced blanking after serialiser reset release (legal 1..1023).
REQ-003 PixelClk  input  1  TMDS pixel clock x1; sole clock; all logic on rising edge.
REQ-004 aRst_n  input  1  One clock; reset is asynchronous and active-low.
REQ-005 aLocked  input  1  MMCM/PLL lock; asynchronous to PixelClk.
REQ-006 pEnable  input  1  Software link enable, PixelClk domain.
REQ-007 pVSync  input  1  Vertical sync from video timing, active-high, PixelClk domain.
REQ-008 pSerdesRst  output  1  Active-high reset to all three data-channel serialisers and the clock-channel serialiser.
REQ-009 pBlank  output  1  Forces TMDS encoders to emit control tokens (C0=C1=0).
REQ-010 pLinkUp  output  1  Link transmitting live video.
REQ-011 pState  output  3  Current state encoding, for status register.
REQ-012 pLockLossCnt  output  8  Count of lock-loss events.

Function
REQ-013 aLocked SHALL pass through a 2-flop synchroniser; lockSync is its output; lockSync rises on the 2nd PixelClk edge after aLocked rises.
REQ-014 States and encodings SHALL be IDLE=0, WAIT_LOCK=1, SERDES_RST=2, SETTLE=3, WAIT_FRAME=4, ACTIVE=5; encodings 6,7 SHALL transition to IDLE.
REQ-015 IDLE -> WAIT_LOCK when pEnable=1.
REQ-016 WAIT_LOCK -> SERDES_RST when lockSync=1; down-counter loaded with kRstCycles-1.
REQ-017 SERDES_RST SHALL last exactly kRstCycles cycles, then -> SETTLE with counter loaded with kSettleCycles-1.
REQ-018 SETTLE SHALL last exactly kSettleCycles cycles, then -> WAIT_FRAME.
REQ-019 WAIT_FRAME -> ACTIVE on the cycle a pVSync rising edge is detected (pVSync=1 and previous-cycle pVSync=0); the edge register updates every cycle in every state.
REQ-020 ACTIVE SHALL persist until an abort condition.
REQ-021 Abort priority: pEnable=0 in any state SHALL force IDLE next cycle, overriding all other transitions.
REQ-022 With pEnable=1, lockSync=0 in SERDES_RST, SETTLE, WAIT_FRAME or ACTIVE SHALL force WAIT_LOCK next cycle and increment pLockLossCnt.
REQ-023 pLockLossCnt SHALL saturate at 255 and clear only on reset; simultaneous pEnable=0 and lock loss SHALL NOT increment it.
REQ-024 Outputs SHALL be Moore-decoded from the state register: pSerdesRst=1 in IDLE, WAIT_LOCK, SERDES_RST; pBlank=1 in all states except ACTIVE; pLinkUp=1 only in ACTIVE; pState=state.
REQ-025 Counter SHALL be 10 bits, SHALL hold 0 outside SERDES_RST/SETTLE, and SHALL never wrap.

Reset
REQ-026 While aRst_n=0: state=IDLE, counter=0, synchroniser flops=0, VSync edge register=0, pLockLossCnt=0, hence pSerdesRst=1, pBlank=1, pLinkUp=0, pState=0.
REQ-027 Reset assertion SHALL take effect without a clock edge; deassertion SHALL be released synchronously by the upstream reset bridge; mid-sequence reset SHALL return to IDLE with no count increment.

Structure
REQ-028 State encodings and default kRstCycles/kSettleCycles constants SHALL live in shared package tmds_pkg.
REQ-029 The synchroniser SHALL be sub-module sync_2ff (1-bit, async active-low reset, reset value 0), reused across the codebase.

Verification
REQ-030 Bring-up: aRst_n high, pEnable=1, aLocked rises at cycle 10 -> SERDES_RST at cycle 13, pSerdesRst falls after exactly 16 cycles, pBlank high a further 64 cycles, pState=4.
REQ-031 Frame sync: in WAIT_FRAME, pVSync held high from entry -> stays WAIT_FRAME; pVSync low then high -> pLinkUp=1 next cycle.
REQ-032 Lock loss in ACTIVE: aLocked drops -> WAIT_LOCK within 3 cycles, pSerdesRst=1, pBlank=1, pLockLossCnt 0->1; relock repeats full sequence.
REQ-033 Saturation: 300 lock-loss events -> pLockLossCnt=255.
REQ-034 Priority: pEnable=0 and aLocked drop on same cycle in ACTIVE -> IDLE, pLockLossCnt unchanged.
REQ-035 Async reset mid-SETTLE: aRst_n low between clock edges -> outputs at reset values immediately; parameters kRstCycles=1, kSettleCycles=1 -> one cycle each.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS link definitions: link-controller state encodings, default
// sequencing lengths and small helpers used by the link controller.
package tmds_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_LOCK  = 3'd1,
      ST_SERDES_RST = 3'd2,
      ST_SETTLE     = 3'd3,
      ST_WAIT_FRAME = 3'd4,
      ST_ACTIVE     = 3'd5
   } link_state_e;

   localparam int unsigned K_RST_CYCLES_DEF    = 16;
   localparam int unsigned K_SETTLE_CYCLES_DEF = 64;
   localparam int unsigned CNT_W               = 10;

   // States that are only meaningful while the MMCM/PLL stays locked.
   function automatic logic needs_lock(input link_state_e s);
      return s inside {ST_SERDES_RST, ST_SETTLE, ST_WAIT_FRAME, ST_ACTIVE};
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchroniser with asynchronous active-low reset to 0.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/tmds_link_ctrl.sv
// TMDS link bring-up sequencer: waits for PLL lock, pulses serialiser reset,
// blanks while lanes settle, then goes live on the first VSync rising edge.
module tmds_link_ctrl
   import tmds_pkg::*;
#(
   parameter int unsigned kRstCycles    = K_RST_CYCLES_DEF,
   parameter int unsigned kSettleCycles = K_SETTLE_CYCLES_DEF
) (
   input  logic       PixelClk,
   input  logic       aRst_n,
   input  logic       aLocked,
   input  logic       pEnable,
   input  logic       pVSync,
   output logic       pSerdesRst,
   output logic       pBlank,
   output logic       pLinkUp,
   output logic [2:0] pState,
   output logic [7:0] pLockLossCnt
);

   localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(kRstCycles - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(kSettleCycles - 1);

   logic              lock_sync;
   logic              vsync_q;
   logic              vsync_rise;
   link_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        loss_q, loss_d;
   logic              serdes_rst_q;
   logic              blank_q;
   logic              link_up_q;

   sync_2ff u_lock_sync (
      .clk_i   (PixelClk),
      .rst_n_i (aRst_n),
      .d_i     (aLocked),
      .q_o     (lock_sync)
   );

   assign vsync_rise = pVSync & ~vsync_q;

   // Disable beats lock loss, so a simultaneous drop never bumps the counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      loss_d  = loss_q;
      if (!pEnable) begin
         state_d = ST_IDLE;
      end else if (needs_lock(state_q) && !lock_sync) begin
         state_d = ST_WAIT_LOCK;
         loss_d  = sat_inc8(loss_q);
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
               if (lock_sync) begin
                  state_d = ST_SERDES_RST;
                  cnt_d   = RST_LOAD;
               end
            end
            ST_SERDES_RST: begin
               if (cnt_q == '0) begin
                  state_d = ST_SETTLE;
                  cnt_d   = SETTLE_LOAD;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            ST_SETTLE: begin
               if (cnt_q == '0) begin
                  state_d = ST_WAIT_FRAME;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            ST_WAIT_FRAME: begin
               if (vsync_rise) begin
                  state_d = ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               state_d = ST_ACTIVE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they line up with state_q.
   always_ff @(posedge PixelClk or negedge aRst_n) begin
      if (!aRst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         vsync_q      <= 1'b0;
         loss_q       <= 8'd0;
         serdes_rst_q <= 1'b1;
         blank_q      <= 1'b1;
         link_up_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         vsync_q      <= pVSync;
         loss_q       <= loss_d;
         serdes_rst_q <= state_d inside {ST_IDLE, ST_WAIT_LOCK, ST_SERDES_RST};
         blank_q      <= (state_d != ST_ACTIVE);
         link_up_q    <= (state_d == ST_ACTIVE);
      end
   end

   assign pSerdesRst   = serdes_rst_q;
   assign pBlank       = blank_q;
   assign pLinkUp      = link_up_q;
   assign pState       = state_q;
   assign pLockLossCnt = loss_q;

endmodule

// File: tb/tb_tmds_link_ctrl.sv
// Directed bench for tmds_link_ctrl: default-length instance plus a
// one-cycle-per-phase instance, checked through an expectation queue.
module tb_tmds_link_ctrl;

   logic       clk;
   logic       rst_n;
   logic       locked;
   logic       en;
   logic       vsync;

   logic       srst0, blank0, up0;
   logic [2:0] state0;
   logic [7:0] cnt0;
   logic       srst1, blank1, up1;
   logic [2:0] state1;
   logic [7:0] cnt1;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      string       sig;
      string       lbl;
      logic [31:0] exp;
   } exp_t;
   exp_t sbq[$];

   tmds_link_ctrl u_dut (
      .PixelClk     (clk),
      .aRst_n       (rst_n),
      .aLocked      (locked),
      .pEnable      (en),
      .pVSync       (vsync),
      .pSerdesRst   (srst0),
      .pBlank       (blank0),
      .pLinkUp      (up0),
      .pState       (state0),
      .pLockLossCnt (cnt0)
   );

   tmds_link_ctrl #(.kRstCycles(1), .kSettleCycles(1)) u_dut1 (
      .PixelClk     (clk),
      .aRst_n       (rst_n),
      .aLocked      (locked),
      .pEnable      (en),
      .pVSync       (vsync),
      .pSerdesRst   (srst1),
      .pBlank       (blank1),
      .pLinkUp      (up1),
      .pState       (state1),
      .pLockLossCnt (cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   function automatic logic [31:0] observe(input string sig);
      case (sig)
         "state":  return {29'd0, state0};
         "srst":   return {31'd0, srst0};
         "blank":  return {31'd0, blank0};
         "up":     return {31'd0, up0};
         "cnt":    return {24'd0, cnt0};
         "state1": return {29'd0, state1};
         "srst1":  return {31'd0, srst1};
         "blank1": return {31'd0, blank1};
         "up1":    return {31'd0, up1};
         "cnt1":   return {24'd0, cnt1};
         default:  return 'x;
      endcase
   endfunction

   task automatic expect_v(input string lbl, input string sig, input logic [31:0] e);
      exp_t x;
      x.sig = sig;
      x.lbl = lbl;
      x.exp = e;
      sbq.push_back(x);
   endtask

   task automatic drain();
      exp_t        x;
      logic [31:0] obs;
      while (sbq.size() > 0) begin
         x   = sbq.pop_front();
         obs = observe(x.sig);
         n_cmp++;
         assert (obs === x.exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", x.lbl, x.sig, obs, x.exp);
         end
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n  = 1'b0;
      en     = 1'b0;
      locked = 1'b0;
      vsync  = 1'b0;
      step(3);
      expect_v("reset", "state", 0);
      expect_v("reset", "srst", 1);
      expect_v("reset", "blank", 1);
      expect_v("reset", "up", 0);
      expect_v("reset", "cnt", 0);
      expect_v("reset", "state1", 0);
      expect_v("reset", "srst1", 1);
      expect_v("reset", "blank1", 1);
      expect_v("reset", "up1", 0);
      expect_v("reset", "cnt1", 0);
      drain();

      rst_n = 1'b1;
      en    = 1'b1;
      step();
      expect_v("enable", "state", 1);
      expect_v("enable", "srst", 1);
      drain();
      step(2);
      expect_v("no_lock", "state", 1);
      drain();

      // Bring-up: two synchroniser edges, then SERDES_RST on the third.
      locked = 1'b1;
      step(2);
      expect_v("sync_lat", "state", 1);
      drain();
      step();
      expect_v("lock_seen", "state", 2);
      expect_v("lock_seen", "srst", 1);
      drain();
      step(15);
      expect_v("srst_last", "state", 2);
      expect_v("srst_last", "srst", 1);
      drain();
      step();
      expect_v("srst_done", "state", 3);
      expect_v("srst_done", "srst", 0);
      expect_v("srst_done", "blank", 1);
      drain();
      vsync = 1'b1;
      step(63);
      expect_v("settle_last", "state", 3);
      expect_v("settle_last", "blank", 1);
      drain();
      step();
      expect_v("wait_frame", "state", 4);
      expect_v("wait_frame", "blank", 1);
      expect_v("wait_frame", "up", 0);
      drain();

      // Frame sync: a held-high VSync is not an edge.
      step(5);
      expect_v("vs_held", "state", 4);
      drain();
      vsync = 1'b0;
      step();
      expect_v("vs_low", "state", 4);
      drain();
      vsync = 1'b1;
      step();
      expect_v("vs_rise", "state", 5);
      expect_v("vs_rise", "up", 1);
      expect_v("vs_rise", "blank", 0);
      expect_v("vs_rise", "srst", 0);
      drain();
      step(4);
      expect_v("active_hold", "state", 5);
      drain();

      // Lock loss in ACTIVE.
      locked = 1'b0;
      step(2);
      expect_v("loss_lat", "state", 5);
      expect_v("loss_lat", "cnt", 0);
      drain();
      step();
      expect_v("loss", "state", 1);
      expect_v("loss", "srst", 1);
      expect_v("loss", "blank", 1);
      expect_v("loss", "up", 0);
      expect_v("loss", "cnt", 1);
      drain();

      // Relock runs the full sequence again.
      locked = 1'b1;
      step(3);
      expect_v("relock", "state", 2);
      drain();
      step(16);
      expect_v("relock_settle", "state", 3);
      drain();
      step(64);
      expect_v("relock_frame", "state", 4);
      drain();
      vsync = 1'b0;
      step();
      vsync = 1'b1;
      step();
      expect_v("relock_active", "state", 5);
      expect_v("relock_active", "up", 1);
      expect_v("relock_active", "cnt", 1);
      drain();

      // Disable and lock loss together: disable wins, no count.
      en     = 1'b0;
      locked = 1'b0;
      step();
      expect_v("prio", "state", 0);
      expect_v("prio", "srst", 1);
      expect_v("prio", "cnt", 1);
      drain();
      step(3);
      expect_v("prio_hold", "state", 0);
      expect_v("prio_hold", "cnt", 1);
      drain();

      // Saturation: 300 lock-loss events from SERDES_RST.
      en = 1'b1;
      step();
      expect_v("sat_start", "state", 1);
      drain();
      for (int k = 1; k <= 300; k++) begin
         locked = 1'b1;
         step(3);
         locked = 1'b0;
         step(3);
         if (k == 199) begin
            expect_v("cnt_200", "cnt", 200);
            expect_v("cnt_200", "state", 1);
            drain();
         end
      end
      expect_v("sat", "cnt", 255);
      expect_v("sat", "state", 1);
      drain();

      // Asynchronous reset in the middle of SETTLE.
      locked = 1'b1;
      step(3 + 16 + 10);
      expect_v("pre_rst", "state", 3);
      expect_v("pre_rst", "cnt", 255);
      drain();
      #3;
      rst_n = 1'b0;
      #1;
      expect_v("arst", "state", 0);
      expect_v("arst", "srst", 1);
      expect_v("arst", "blank", 1);
      expect_v("arst", "up", 0);
      expect_v("arst", "cnt", 0);
      drain();

      // Minimum-length instance: one cycle each in SERDES_RST and SETTLE.
      step();
      rst_n = 1'b1;
      step();
      expect_v("min_wait", "state1", 1);
      drain();
      step();
      expect_v("min_sync", "state1", 1);
      drain();
      step();
      expect_v("min_srst", "state1", 2);
      expect_v("min_srst", "srst1", 1);
      drain();
      step();
      expect_v("min_settle", "state1", 3);
      expect_v("min_settle", "srst1", 0);
      expect_v("min_settle", "blank1", 1);
      drain();
      step();
      expect_v("min_frame", "state1", 4);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
